// File: rtl/axi_lite_slv_bridge_if.sv
// AXI4-Lite channel bundle between an initiator (master) and axi_lite_slv_bridge (slave).
// A transfer occurs on a rising clk edge where VALID and READY are both 1; VALID never waits on READY and payload is stable while VALID is high.
interface axi_lite_slv_bridge_if;
  logic [31:0] s_awaddr;
  logic        s_awvalid;
  logic        s_awready;
  logic [31:0] s_wdata;
  logic [3:0]  s_wstrb;
  logic        s_wvalid;
  logic        s_wready;
  logic [1:0]  s_bresp;
  logic        s_bvalid;
  logic        s_bready;
  logic [31:0] s_araddr;
  logic        s_arvalid;
  logic        s_arready;
  logic [31:0] s_rdata;
  logic [1:0]  s_rresp;
  logic        s_rvalid;
  logic        s_rready;

  modport slave (
    input  s_awaddr, s_awvalid, s_wdata, s_wstrb, s_wvalid, s_bready,
           s_araddr, s_arvalid, s_rready,
    output s_awready, s_wready, s_bresp, s_bvalid, s_arready,
           s_rdata, s_rresp, s_rvalid
  );

  modport master (
    output s_awaddr, s_awvalid, s_wdata, s_wstrb, s_wvalid, s_bready,
           s_araddr, s_arvalid, s_rready,
    input  s_awready, s_wready, s_bresp, s_bvalid, s_arready,
           s_rdata, s_rresp, s_rvalid
  );
endinterface

// File: rtl/axi_lite_slv_bridge.sv
// AXI4-Lite slave that turns single read/write transactions into one-cycle
// strobes on a local register bus; one transaction outstanding at a time.
module axi_lite_slv_bridge #(
  parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
  parameter int          LOCAL_AW  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  axi_lite_slv_bridge_if.slave s_axi,
  output logic [LOCAL_AW-1:0]  addr,
  output logic                 wr,
  output logic                 rd,
  output logic [31:0]          wdata,
  input  logic [31:0]          rdata,
  output logic [2:0]           o_dbg_state
);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_W, S_WAIT_AW, S_WR_EXEC, S_WR_RESP, S_RD_EXEC, S_RD_RESP
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [31:0]        r_awaddr;
  logic [31:0]        r_wd_lat;
  logic [3:0]         r_wstrb_lat;
  logic [LOCAL_AW-1:0] r_addr;
  logic [31:0]        r_wdata;
  logic               r_wr;
  logic               r_rd;
  logic               r_rd_ok;
  logic [1:0]         r_bresp;
  logic [31:0]        r_rdata;
  logic [1:0]         r_rresp;

  logic        w_idle;
  logic        w_aw_hs;
  logic        w_w_hs;
  logic        w_ar_hs;
  logic        w_wr_go;
  logic [31:0] w_wr_addr;
  logic [31:0] w_wr_data;
  logic [3:0]  w_wr_strb;
  logic        w_wr_ok;
  logic        w_rd_ok;

  assign w_idle = (r_state == S_IDLE);

  assign s_axi.s_awready = !rst && (w_idle || r_state == S_WAIT_AW);
  assign s_axi.s_wready  = !rst && (w_idle || r_state == S_WAIT_W);
  assign s_axi.s_arready = !rst && w_idle && !s_axi.s_awvalid && !s_axi.s_wvalid;

  assign w_aw_hs = s_axi.s_awvalid && s_axi.s_awready;
  assign w_w_hs  = s_axi.s_wvalid  && s_axi.s_wready;
  assign w_ar_hs = s_axi.s_arvalid && s_axi.s_arready;

  assign w_wr_go = (w_idle && w_aw_hs && w_w_hs) ||
                   (r_state == S_WAIT_W && w_w_hs) ||
                   (r_state == S_WAIT_AW && w_aw_hs);

  // Whichever channel arrived first was latched; the later one is still on the bus.
  assign w_wr_addr = (r_state == S_WAIT_W)  ? r_awaddr    : s_axi.s_awaddr;
  assign w_wr_data = (r_state == S_WAIT_AW) ? r_wd_lat    : s_axi.s_wdata;
  assign w_wr_strb = (r_state == S_WAIT_AW) ? r_wstrb_lat : s_axi.s_wstrb;

  assign w_wr_ok = (w_wr_addr[31:16] == BASE_ADDR[31:16]) && (w_wr_addr[1:0] == 2'b00) &&
                   (w_wr_strb == 4'hF);
  assign w_rd_ok = (s_axi.s_araddr[31:16] == BASE_ADDR[31:16]) && (s_axi.s_araddr[1:0] == 2'b00);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_aw_hs && w_w_hs) w_next = S_WR_EXEC;
        else if (w_aw_hs)      w_next = S_WAIT_W;
        else if (w_w_hs)       w_next = S_WAIT_AW;
        else if (w_ar_hs)      w_next = S_RD_EXEC;
      end
      S_WAIT_W:  if (w_w_hs)  w_next = S_WR_EXEC;
      S_WAIT_AW: if (w_aw_hs) w_next = S_WR_EXEC;
      S_WR_EXEC: w_next = S_WR_RESP;
      S_WR_RESP: if (s_axi.s_bready) w_next = S_IDLE;
      S_RD_EXEC: w_next = S_RD_RESP;
      S_RD_RESP: if (s_axi.s_rready) w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_awaddr    <= '0;
      r_wd_lat    <= '0;
      r_wstrb_lat <= '0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_wr        <= 1'b0;
      r_rd        <= 1'b0;
      r_rd_ok     <= 1'b0;
      r_bresp     <= RESP_OKAY;
      r_rdata     <= '0;
      r_rresp     <= RESP_OKAY;
    end else begin
      r_wr <= 1'b0;
      r_rd <= 1'b0;
      if (w_idle && w_aw_hs && !w_w_hs) r_awaddr <= s_axi.s_awaddr;
      if (w_idle && w_w_hs && !w_aw_hs) begin
        r_wd_lat    <= s_axi.s_wdata;
        r_wstrb_lat <= s_axi.s_wstrb;
      end
      // Strobe and local address are registered at the handshake edge so they are valid during the EXEC cycle.
      if (w_wr_go) begin
        r_wr    <= w_wr_ok;
        r_bresp <= w_wr_ok ? RESP_OKAY : RESP_SLVERR;
        if (w_wr_ok) begin
          r_addr  <= w_wr_addr[LOCAL_AW-1:0];
          r_wdata <= w_wr_data;
        end
      end
      if (w_ar_hs) begin
        r_rd    <= w_rd_ok;
        r_rd_ok <= w_rd_ok;
        if (w_rd_ok) r_addr <= s_axi.s_araddr[LOCAL_AW-1:0];
      end
      if (r_state == S_RD_EXEC) begin
        r_rdata <= r_rd_ok ? rdata : 32'h0;
        r_rresp <= r_rd_ok ? RESP_OKAY : RESP_SLVERR;
      end
    end
  end

  assign addr  = r_addr;
  assign wdata = r_wdata;
  assign wr    = r_wr;
  assign rd    = r_rd;

  assign s_axi.s_bvalid = (r_state == S_WR_RESP);
  assign s_axi.s_bresp  = r_bresp;
  assign s_axi.s_rvalid = (r_state == S_RD_RESP);
  assign s_axi.s_rdata  = r_rdata;
  assign s_axi.s_rresp  = r_rresp;

  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_axi_lite_slv_bridge.sv
// Bench for axi_lite_slv_bridge: directed scenarios plus random traffic, with
// a register-file reference model and a queue-based scoreboard on every output channel.
module tb_axi_lite_slv_bridge;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  axi_lite_slv_bridge_if vif();

  logic [15:0] addr;
  logic        wr;
  logic        rd;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [2:0]  dbg_state;

  logic [31:0] periph_mem [64];
  logic [31:0] model_mem  [64];
  logic        load_mem = 1'b1;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int b_mode = 0;
  int r_mode = 0;

  logic [47:0] exp_wr_q[$];
  int          exp_wrcyc_q[$];
  logic [15:0] exp_rd_q[$];
  int          exp_rdcyc_q[$];
  logic [1:0]  exp_b_q[$];
  int          exp_bcyc_q[$];
  logic [33:0] exp_r_q[$];
  int          exp_rcyc_q[$];

  axi_lite_slv_bridge dut (
    .clk        (clk),
    .rst        (rst),
    .s_axi      (vif),
    .addr       (addr),
    .wr         (wr),
    .rd         (rd),
    .wdata      (wdata),
    .rdata      (rdata),
    .o_dbg_state(dbg_state)
  );

  // Peripheral register file seen by the local bus.
  assign rdata = periph_mem[addr[7:2]];
  always @(posedge clk) begin
    if (load_mem) begin
      for (int i = 0; i < 64; i++) periph_mem[i] <= model_mem[i];
    end else if (wr) begin
      periph_mem[addr[7:2]] <= wdata;
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [47:0] got, input logic [47:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  task automatic wait_ready(input int which, output int t);
    bit done;
    int n;
    done = 1'b0;
    n = 0;
    t = -100;
    while (!done && n < 50) begin
      @(negedge clk);
      n++;
      if ((which == 0 && vif.s_awready && vif.s_wready) ||
          (which == 1 && vif.s_awready) ||
          (which == 2 && vif.s_wready) ||
          (which == 3 && vif.s_arready)) begin
        done = 1'b1;
        t = cyc;
      end
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL hs_timeout channel=%0d got no ready want ready within 50 cycles", which);
    end
  endtask

  task automatic wait_resp(input bit is_b);
    bit done;
    int n;
    done = 1'b0;
    n = 0;
    while (!done && n < 80) begin
      @(negedge clk);
      n++;
      if (is_b ? (vif.s_bvalid && vif.s_bready) : (vif.s_rvalid && vif.s_rready)) done = 1'b1;
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL resp_timeout is_b=%0d got no response want response within 80 cycles", is_b);
    end
  endtask

  // lead > 0: W handshakes lead cycles before AW; lead < 0: AW leads; 0: same cycle.
  task automatic wr_txn(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                        input int lead, input bit wait_done);
    int t;
    bit ok;
    ok = (a[31:16] == 16'h4000) && (a[1:0] == 2'b00) && (s == 4'hF);
    @(posedge clk); #1;
    vif.s_awaddr = a;
    vif.s_wdata  = d;
    vif.s_wstrb  = s;
    if (lead == 0) begin
      vif.s_awvalid = 1'b1;
      vif.s_wvalid  = 1'b1;
      wait_ready(0, t);
    end else if (lead > 0) begin
      vif.s_wvalid = 1'b1;
      wait_ready(2, t);
      @(posedge clk); #1;
      vif.s_wvalid = 1'b0;
      vif.s_wdata  = $urandom();
      vif.s_wstrb  = 4'($urandom());
      repeat (lead - 1) begin @(posedge clk); #1; end
      vif.s_awvalid = 1'b1;
      wait_ready(1, t);
    end else begin
      vif.s_awvalid = 1'b1;
      wait_ready(1, t);
      @(posedge clk); #1;
      vif.s_awvalid = 1'b0;
      vif.s_awaddr  = $urandom();
      repeat (-lead - 1) begin @(posedge clk); #1; end
      vif.s_wvalid = 1'b1;
      wait_ready(2, t);
    end
    exp_b_q.push_back(ok ? 2'b00 : 2'b10);
    exp_bcyc_q.push_back(t + 2);
    if (ok) begin
      exp_wr_q.push_back({a[15:0], d});
      exp_wrcyc_q.push_back(t + 1);
      model_mem[a[7:2]] = d;
    end
    @(posedge clk); #1;
    vif.s_awvalid = 1'b0;
    vif.s_wvalid  = 1'b0;
    vif.s_awaddr  = $urandom();
    vif.s_wdata   = $urandom();
    vif.s_wstrb   = 4'($urandom());
    if (wait_done) wait_resp(1'b1);
  endtask

  task automatic rd_txn(input logic [31:0] a, input bit wait_done);
    int t;
    bit ok;
    ok = (a[31:16] == 16'h4000) && (a[1:0] == 2'b00);
    @(posedge clk); #1;
    vif.s_araddr  = a;
    vif.s_arvalid = 1'b1;
    wait_ready(3, t);
    exp_r_q.push_back(ok ? {2'b00, model_mem[a[7:2]]} : {2'b10, 32'h0});
    exp_rcyc_q.push_back(t + 2);
    if (ok) begin
      exp_rd_q.push_back(a[15:0]);
      exp_rdcyc_q.push_back(t + 1);
    end
    @(posedge clk); #1;
    vif.s_arvalid = 1'b0;
    vif.s_araddr  = $urandom();
    if (wait_done) wait_resp(1'b0);
  endtask

  task automatic check_reset_state();
    chk("rst_addr",    48'(addr), 48'd0);
    chk("rst_wdata",   48'(wdata), 48'd0);
    chk("rst_wr",      48'(wr), 48'd0);
    chk("rst_rd",      48'(rd), 48'd0);
    chk("rst_bvalid",  48'(vif.s_bvalid), 48'd0);
    chk("rst_bresp",   48'(vif.s_bresp), 48'd0);
    chk("rst_rvalid",  48'(vif.s_rvalid), 48'd0);
    chk("rst_rresp",   48'(vif.s_rresp), 48'd0);
    chk("rst_rdata",   48'(vif.s_rdata), 48'd0);
    chk("rst_awready", 48'(vif.s_awready), 48'd0);
    chk("rst_wready",  48'(vif.s_wready), 48'd0);
    chk("rst_arready", 48'(vif.s_arready), 48'd0);
    chk("rst_state",   48'(dbg_state), 48'd0);
  endtask

  // Response-ready driver, updated just after each rising edge.
  initial begin
    vif.s_bready = 1'b0;
    vif.s_rready = 1'b0;
    forever begin
      @(posedge clk); #2;
      vif.s_bready = (b_mode == 0) ? 1'b1 : (b_mode == 1) ? ($urandom_range(0, 2) != 0) : 1'b0;
      vif.s_rready = (r_mode == 0) ? 1'b1 : (r_mode == 1) ? ($urandom_range(0, 2) != 0) : 1'b0;
    end
  end

  // Monitor / scoreboard.
  initial begin
    bit pb;
    bit pr;
    pb = 1'b0;
    pr = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (wr || rd) chk("wr_rd_exclusive", 48'(wr && rd), 48'd0);
        if (wr) begin
          if (exp_wr_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL wr_unexpected got wr=1 addr=%0h want no write", addr);
          end else begin
            chk("wr_addr_data", {addr, wdata}, exp_wr_q.pop_front());
            chk("wr_cycle", 48'(cyc), 48'(exp_wrcyc_q.pop_front()));
          end
        end
        if (rd) begin
          if (exp_rd_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL rd_unexpected got rd=1 addr=%0h want no read", addr);
          end else begin
            chk("rd_addr", 48'(addr), 48'(exp_rd_q.pop_front()));
            chk("rd_cycle", 48'(cyc), 48'(exp_rdcyc_q.pop_front()));
          end
        end
        if (vif.s_bvalid) begin
          if (exp_b_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL b_unexpected got bvalid=1 want no response");
          end else begin
            if (!pb) chk("b_rise_cycle", 48'(cyc), 48'(exp_bcyc_q.pop_front()));
            chk("bresp", 48'(vif.s_bresp), 48'(exp_b_q[0]));
            if (vif.s_bready) void'(exp_b_q.pop_front());
          end
        end
        if (vif.s_rvalid) begin
          if (exp_r_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL r_unexpected got rvalid=1 want no response");
          end else begin
            if (!pr) chk("r_rise_cycle", 48'(cyc), 48'(exp_rcyc_q.pop_front()));
            chk("rresp_rdata", 48'({vif.s_rresp, vif.s_rdata}), 48'(exp_r_q[0]));
            if (vif.s_rready) void'(exp_r_q.pop_front());
          end
        end
        if (vif.s_arvalid && vif.s_arready)
          chk("ar_write_priority", 48'({vif.s_awvalid, vif.s_wvalid}), 48'd0);
      end
      pb = vif.s_bvalid;
      pr = vif.s_rvalid;
    end
  end

  initial begin
    int n;
    logic [31:0] a;
    logic [31:0] d;
    vif.s_awaddr  = '0;
    vif.s_awvalid = 1'b0;
    vif.s_wdata   = '0;
    vif.s_wstrb   = '0;
    vif.s_wvalid  = 1'b0;
    vif.s_araddr  = '0;
    vif.s_arvalid = 1'b0;
    for (int i = 0; i < 64; i++) model_mem[i] = $urandom();
    model_mem[3] = 32'h1234_5678;

    repeat (3) @(posedge clk);
    #1 load_mem = 1'b0;
    @(negedge clk);
    check_reset_state();
    @(posedge clk); #1;
    rst = 1'b0;

    wr_txn(32'h4000_0004, 32'hDEAD_BEEF, 4'hF, 0, 1'b1);
    wr_txn(32'h4000_0008, 32'hA5A5_0F0F, 4'hF, 3, 1'b1);

    r_mode = 2;
    fork
      rd_txn(32'h4000_000C, 1'b1);
      begin repeat (6) @(negedge clk); r_mode = 0; end
    join

    wr_txn(32'h5000_0000, 32'hCAFE_0001, 4'hF, 0, 1'b1);
    wr_txn(32'h4000_0010, 32'hCAFE_0002, 4'h3, 0, 1'b1);
    rd_txn(32'h4000_0002, 1'b1);

    fork
      wr_txn(32'h4000_0014, 32'h0BAD_F00D, 4'hF, 0, 1'b1);
      rd_txn(32'h4000_0014, 1'b1);
    join

    b_mode = 2;
    wr_txn(32'h4000_0018, 32'h7777_1111, 4'hF, 0, 1'b0);
    n = 0;
    while (!vif.s_bvalid && n < 20) begin @(negedge clk); n++; end
    chk("b_pending_before_rst", 48'(vif.s_bvalid), 48'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_reset_state();
    exp_b_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    b_mode = 0;
    wr_txn(32'h4000_001C, 32'h3C3C_5A5A, 4'hF, -2, 1'b1);
    rd_txn(32'h4000_0018, 1'b1);

    @(negedge clk);
    b_mode = 1;
    r_mode = 1;
    for (int k = 0; k < 40; k++) begin
      int err;
      int lead;
      logic [3:0] s;
      err = int'($urandom_range(0, 6));
      lead = int'($urandom_range(0, 4)) - 2;
      a = {16'h4000, 8'($urandom()), 6'($urandom_range(0, 63)), 2'b00};
      d = $urandom();
      s = 4'hF;
      if (err == 0) a[31:16] = 16'h4000 ^ 16'($urandom_range(1, 65535));
      if (err == 1) a[1:0] = 2'($urandom_range(1, 3));
      if (err == 2) s = 4'($urandom_range(0, 14));
      if ($urandom_range(0, 1) == 0) wr_txn(a, d, s, lead, 1'b1);
      else                           rd_txn(a, 1'b1);
    end

    repeat (5) @(negedge clk);
    chk("wr_q_drained", 48'(exp_wr_q.size()), 48'd0);
    chk("rd_q_drained", 48'(exp_rd_q.size()), 48'd0);
    chk("b_q_drained",  48'(exp_b_q.size()), 48'd0);
    chk("r_q_drained",  48'(exp_r_q.size()), 48'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
